// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU control path: state encoding,
// opcode values, instruction field positions and the decoded-instruction record.
// Ports: none (package).
package cpu_pkg;

  // Default datapath geometry
  localparam int CPU_DATA_W = 16;  // instruction / data width
  localparam int CPU_PC_W   = 5;   // 32-word instruction space
  localparam int CPU_RA_W   = 3;   // R0-R7
  localparam int CPU_FUNC_W = 4;   // 16 ALU functions
  localparam int CPU_IMM_W  = 8;   // LDI immediate width
  localparam int CPU_OP_W   = 3;   // non-ALU opcode width

  // Controller states; every instruction walks FETCH -> DECODE -> EXEC -> WB
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_t;

  // Opcodes for bit15 = 0 instructions; 100/101/110 are undefined
  localparam logic [CPU_OP_W-1:0] OP_NOP  = 3'b000;
  localparam logic [CPU_OP_W-1:0] OP_LDI  = 3'b001;
  localparam logic [CPU_OP_W-1:0] OP_JMP  = 3'b010;
  localparam logic [CPU_OP_W-1:0] OP_BZ   = 3'b011;
  localparam logic [CPU_OP_W-1:0] OP_HALT = 3'b111;

  // Instruction field bit positions
  localparam int ALU_BIT = 15;
  localparam int FUNC_HI = 14;
  localparam int FUNC_LO = 11;
  localparam int OP_HI   = 14;
  localparam int OP_LO   = 12;
  localparam int RD_HI   = 10;
  localparam int RD_LO   = 8;
  localparam int RS1_HI  = 7;
  localparam int RS1_LO  = 5;
  localparam int RS2_HI  = 4;
  localparam int RS2_LO  = 2;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;
  localparam int TGT_HI  = 4;
  localparam int TGT_LO  = 0;

  // Every field of an instruction, extracted regardless of format;
  // consumers qualify with is_alu / op.
  typedef struct packed {
    logic                  is_alu;
    logic [CPU_OP_W-1:0]   op;
    logic [CPU_RA_W-1:0]   rd;
    logic [CPU_RA_W-1:0]   rs1;
    logic [CPU_RA_W-1:0]   rs2;
    logic [CPU_FUNC_W-1:0] func;
    logic [CPU_IMM_W-1:0]  imm;
    logic [CPU_PC_W-1:0]   target;
    logic                  is_illegal;
  } dec_t;

  // Undefined non-ALU opcodes
  function automatic logic op_is_illegal(input logic [CPU_OP_W-1:0] op);
    return (op == 3'b100) || (op == 3'b101) || (op == 3'b110);
  endfunction

endpackage

// File: rtl/cpu_controller_instr_decoder.sv
// Instruction decoder: splits a 16-bit instruction word into its fields.
// Latency: purely combinational, zero cycles. Backpressure: none.
// Ports: instr (raw instruction word in), dec (decoded field record out).
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [CPU_DATA_W-1:0] instr,
  output dec_t                  dec
);

  logic [CPU_OP_W-1:0] op;

  assign op = instr[OP_HI:OP_LO];

  always_comb begin
    dec            = '0;
    dec.is_alu     = instr[ALU_BIT];
    dec.op         = op;
    dec.rd         = instr[RD_HI:RD_LO];
    dec.rs1        = instr[RS1_HI:RS1_LO];
    dec.rs2        = instr[RS2_HI:RS2_LO];
    dec.func       = instr[FUNC_HI:FUNC_LO];
    dec.imm        = instr[IMM_HI:IMM_LO];
    dec.target     = instr[TGT_HI:TGT_LO];
    // ALU-format words are always legal; only the non-ALU opcode space has holes
    dec.is_illegal = !instr[ALU_BIT] && op_is_illegal(op);
  end

endmodule

// File: rtl/cpu_controller.sv
// Multicycle control FSM for the 16-bit CPU: sequences fetch/decode/exec/write-back,
// owns the PC, instruction register and zero flag. Latency: 4 cycles per instruction.
// Backpressure: run=0 parks the FSM in FETCH at the next instruction boundary.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   run                   1 = execute, 0 = pause in FETCH
//   imem_data, imem_addr  synchronous instruction ROM (data one cycle after addr)
//   alu_zero              ALU result == 0, sampled in EXEC for ALU ops
//   rf_ra1, rf_ra2        register read addresses
//   rf_wa, rf_we, wb_sel  register write address/enable, write source (1 = imm)
//   imm_out               zero-extended LDI immediate
//   alu_func              ALU function select (EXEC only)
//   pc_out                current PC
//   retire, halted, illegal  status: WB pulse, HALT reached, sticky undefined opcode
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int PC_W   = CPU_PC_W,
  parameter int RA_W   = CPU_RA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              alu_zero,
  output logic [PC_W-1:0]   imem_addr,
  output logic [RA_W-1:0]   rf_ra1,
  output logic [RA_W-1:0]   rf_ra2,
  output logic [RA_W-1:0]   rf_wa,
  output logic              rf_we,
  output logic              wb_sel,
  output logic [DATA_W-1:0] imm_out,
  output logic [3:0]        alu_func,
  output logic [PC_W-1:0]   pc_out,
  output logic              retire,
  output logic              halted,
  output logic              illegal
);

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] ir;
  logic              zero_flag;

  logic [DATA_W-1:0] dec_src;
  dec_t              dec;

  logic is_ldi;
  logic is_jmp;
  logic is_bz;
  logic is_halt;
  logic writes_rf;

  // In DECODE the word is still on the ROM bus and IR is loaded at the end of
  // the cycle, so decode straight from imem_data there; afterwards from IR.
  // One decoder thereby serves both the early read addresses and the later
  // EXEC/WB controls.
  assign dec_src = (state == DECODE) ? imem_data : ir;

  instr_decoder u_instr_decoder (
    .instr (dec_src),
    .dec   (dec)
  );

  assign is_ldi    = !dec.is_alu && (dec.op == OP_LDI);
  assign is_jmp    = !dec.is_alu && (dec.op == OP_JMP);
  assign is_bz     = !dec.is_alu && (dec.op == OP_BZ);
  assign is_halt   = !dec.is_alu && (dec.op == OP_HALT);
  assign writes_rf = dec.is_alu || is_ldi;

  assign imem_addr = pc;
  assign pc_out    = pc;
  assign rf_ra1    = dec.rs1;
  assign rf_ra2    = dec.rs2;

  // Controls for a state are registered on the edge that enters it, so each
  // output is glitch-free and the async reset clears them mid-cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= '0;
      ir        <= '0;
      zero_flag <= 1'b0;
      illegal   <= 1'b0;
      rf_we     <= 1'b0;
      rf_wa     <= '0;
      wb_sel    <= 1'b0;
      imm_out   <= '0;
      alu_func  <= '0;
      retire    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          // Only point where run is honoured; PC holds while paused
          if (run) begin
            state <= DECODE;
          end
        end

        DECODE: begin
          ir       <= imem_data;
          alu_func <= dec.is_alu ? dec.func : '0;
          state    <= EXEC;
        end

        EXEC: begin
          alu_func <= '0;
          // Only ALU ops own the flag; BZ sees the last ALU result
          if (dec.is_alu) begin
            zero_flag <= alu_zero;
          end
          if (is_halt) begin
            // PC is left pointing at the HALT word
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            retire  <= 1'b1;
            rf_we   <= writes_rf;
            rf_wa   <= writes_rf ? dec.rd : '0;
            wb_sel  <= is_ldi;
            imm_out <= is_ldi ? DATA_W'(dec.imm) : '0;
            if (dec.is_illegal) begin
              illegal <= 1'b1;
            end
            state <= WB;
          end
        end

        WB: begin
          retire  <= 1'b0;
          rf_we   <= 1'b0;
          rf_wa   <= '0;
          wb_sel  <= 1'b0;
          imm_out <= '0;
          if (is_jmp || (is_bz && zero_flag)) begin
            pc <= dec.target;
          end else begin
            pc <= pc + PC_W'(1);  // natural wrap 31 -> 0
          end
          state <= FETCH;
        end

        HALT: begin
          // Terminal; only reset leaves
          state <= HALT;
        end

        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
